// File: rtl/demux4_buffered_pkg.sv
// Shared constants for the 1-to-4 buffered demultiplexer: channel ids and default sizes.
package demux4_buffered_pkg;

  localparam int NUM_CH             = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 2;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    CH_WB  = 2'd0,
    CH_MEM = 2'd1,
    CH_DBG = 2'd2,
    CH_AUX = 2'd3
  } ch_e;

endpackage

// File: rtl/demux4_buffered_if.sv
// Upstream valid/ready stream plus the four per-channel drain ports of demux4_buffered.
interface demux4_buffered_if
  import demux4_buffered_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   in_select;
  logic [DATA_WIDTH-1:0]        in_data;
  logic [NUM_CH-1:0]            out_valid;
  logic [NUM_CH-1:0]            out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;
  logic                         busy;

  modport master (
    output in_valid, in_select, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_select, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/demux4_buffered_chan_fifo.sv
// Single-clock circular FIFO for one demux channel; the head word is held in its own register.
module demux_chan_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign valid = (count_q != '0);
  assign head  = head_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Head tracks the oldest word; when the last word leaves it keeps its old value.
    if (pop) begin
      if (count_q > CNT_W'(1)) head_d = mem_q[rd_ptr_d];
      else if (push)           head_d = push_data;
    end else if (!valid && push) begin
      head_d = push_data;
    end
  end

  // NOTE: the storage array has no reset; only pointers, count and head are cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end
endmodule

// File: rtl/demux4_buffered.sv
// 1-to-4 buffered demux: steers a tagged stream into four independent channel FIFOs.
// Optional per-channel transfer counters are built when DEMUX4_STATS_EN is defined.
module demux4_buffered
  import demux4_buffered_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
`ifdef DEMUX4_STATS_EN
  ,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
`endif
) (
  input  logic clk,
  input  logic rst_n,
  demux4_buffered_if.slave bus
`ifdef DEMUX4_STATS_EN
  ,
  input  logic                        stat_clear,
  output logic [NUM_CH*CNT_WIDTH-1:0] stat_count
`endif
);
  ch_e                   sel;
  logic                  in_ready;
  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [NUM_CH-1:0]     valid;
  logic [DATA_WIDTH-1:0] head [NUM_CH];

  assign sel      = ch_e'(bus.in_select);
  // Ready depends only on the addressed channel's registered fill state.
  assign in_ready = ~full[bus.in_select];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k] = bus.in_valid && in_ready && (sel == ch_e'(k));
    assign pop[k]  = valid[k] && bus.out_ready[k];

    demux_chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[k]),
      .push_data (bus.in_data),
      .full      (full[k]),
      .pop       (pop[k]),
      .valid     (valid[k]),
      .head      (head[k])
    );

    assign bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = head[k];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid;
  assign bus.busy      = |valid;

`ifdef DEMUX4_STATS_EN
  logic [CNT_WIDTH-1:0] stat_q [NUM_CH];
  logic [CNT_WIDTH-1:0] stat_d [NUM_CH];

  // Clear wins over an increment; counters stick at all-ones.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      stat_d[k] = stat_q[k];
      if (stat_clear)                     stat_d[k] = '0;
      else if (pop[k] && (stat_q[k] != '1)) stat_d[k] = stat_q[k] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) stat_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) stat_q[k] <= stat_d[k];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
    assign stat_count[k*CNT_WIDTH +: CNT_WIDTH] = stat_q[k];
  end
`endif
endmodule

// File: tb/tb_demux4_buffered.sv
// Self-checking bench for demux4_buffered: vector table plus reset, wrap and stats sequences.
module tb_demux4_buffered;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  demux4_buffered_if #(.DATA_WIDTH(DW)) bus ();

`ifdef DEMUX4_STATS_EN
  logic        stat_clear = 1'b0;
  logic [15:0] stat_count;

  demux4_buffered #(.DATA_WIDTH(DW), .DEPTH(2), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .stat_clear (stat_clear),
    .stat_count (stat_count)
  );
`else
  demux4_buffered #(.DATA_WIDTH(DW), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic        chk;
    logic [1:0]  chk_ch;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] sel, input logic [31:0] data,
                       input logic [3:0] ordy);
    bus.in_valid  = vld;
    bus.in_select = sel;
    bus.in_data   = data;
    bus.out_ready = ordy;
  endtask

  function automatic logic [31:0] head_of(input int ch);
    return bus.out_data[ch*DW +: DW];
  endfunction

`ifdef DEMUX4_STATS_EN
  task automatic xfer(input logic [1:0] ch);
    drive(1'b1, ch, 32'h100 + 32'(ch), 4'b0000);
    @(posedge clk); #1;
    drive(1'b0, ch, 32'h0, 4'b0001 << ch);
    @(posedge clk); #1;
    bus.out_ready = 4'b0000;
  endtask
`endif

  initial begin
    logic [31:0] rcv [10];
    int sent, got, cyc;
    logic do_push, do_pop;
    logic [31:0] pop_val;

    //           vld  sel   data          ordy     rdy   ov       chk  ch    head
    vecs[0]  = '{1'b1, 2'd1, 32'h0000_0011, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h11};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,         4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h0};
    vecs[2]  = '{1'b1, 2'd0, 32'h1,         4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h1};
    vecs[3]  = '{1'b1, 2'd0, 32'h2,         4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h1};
    vecs[4]  = '{1'b1, 2'd0, 32'hDEAD,      4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h1};
    vecs[5]  = '{1'b1, 2'd3, 32'h3,         4'b0000, 1'b1, 4'b1001, 1'b1, 2'd3, 32'h3};
    vecs[6]  = '{1'b0, 2'd3, 32'h0,         4'b0001, 1'b1, 4'b1001, 1'b1, 2'd0, 32'h2};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,         4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[8]  = '{1'b1, 2'd1, 32'h6,         4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h6};
    vecs[9]  = '{1'b1, 2'd1, 32'h7,         4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h7};
    vecs[10] = '{1'b0, 2'd1, 32'h0,         4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h0};
    vecs[11] = '{1'b1, 2'd2, 32'h21,        4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h21};
    vecs[12] = '{1'b1, 2'd2, 32'h22,        4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h21};
    vecs[13] = '{1'b1, 2'd2, 32'h23,        4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 32'h22};
    vecs[14] = '{1'b1, 2'd2, 32'h23,        4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h23};
    vecs[15] = '{1'b0, 2'd2, 32'h0,         4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h0};

    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    #2;
    check("reset_out_valid", 128'(bus.out_valid), 128'(4'b0000));
    check("reset_busy",      128'(bus.busy),      128'(1'b0));
    check("reset_in_ready",  128'(bus.in_ready),  128'(1'b1));
    check("reset_out_data",  128'(bus.out_data),  128'(0));
`ifdef DEMUX4_STATS_EN
    check("reset_stat_count", 128'(stat_count), 128'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), 128'(bus.out_valid), 128'(vecs[i].exp_ov));
      check($sformatf("vec%0d_busy", i), 128'(bus.busy), 128'(|vecs[i].exp_ov));
      if (vecs[i].chk)
        check($sformatf("vec%0d_head_ch%0d", i, vecs[i].chk_ch),
              128'(head_of(int'(vecs[i].chk_ch))), 128'(vecs[i].exp_head));
    end

    // Stream 0..9 through channel 3 while its consumer alternates ready.
    sent = 0; got = 0; cyc = 0;
    while ((got < 10) && (cyc < 200)) begin
      drive(sent < 10, 2'd3, 32'(sent), {cyc[0] == 0, 3'b000});
      #1;
      do_push = bus.in_valid && bus.in_ready;
      do_pop  = bus.out_valid[3] && bus.out_ready[3];
      pop_val = head_of(3);
      @(posedge clk); #1;
      if (do_push) sent++;
      if (do_pop) begin
        rcv[got] = pop_val;
        got++;
      end
      cyc++;
    end
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    check("wrap_words_received", 128'(got), 128'(10));
    for (int i = 0; i < 10; i++)
      if (i < got) check($sformatf("wrap_word%0d", i), 128'(rcv[i]), 128'(i));
    #1;
    check("wrap_drained", 128'(bus.out_valid), 128'(4'b0000));

    // Reset while a word sits in channel 2.
    drive(1'b1, 2'd2, 32'hA5A5_A5A5, 4'b0000);
    @(posedge clk); #1;
    drive(1'b0, 2'd2, 32'h0, 4'b0000);
    check("inflight_out_valid", 128'(bus.out_valid), 128'(4'b0100));
    check("inflight_head", 128'(head_of(2)), 128'(32'hA5A5_A5A5));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 128'(bus.out_valid), 128'(4'b0000));
    check("async_reset_busy", 128'(bus.busy), 128'(1'b0));
    check("async_reset_out_data", 128'(bus.out_data), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("post_reset_busy", 128'(bus.busy), 128'(1'b0));

`ifdef DEMUX4_STATS_EN
    for (int i = 0; i < 5; i++) xfer(2'd0);
    for (int i = 0; i < 3; i++) xfer(2'd2);
    check("stats_5_0_3_0", 128'(stat_count), 128'({4'd0, 4'd3, 4'd0, 4'd5}));
    drive(1'b1, 2'd0, 32'h55, 4'b0000);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 32'h0, 4'b0001);
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    bus.out_ready = 4'b0000;
    check("stats_clear_priority", 128'(stat_count), 128'(0));
    check("stats_clear_xfer_done", 128'(bus.out_valid), 128'(4'b0000));
    for (int i = 0; i < 20; i++) xfer(2'd1);
    check("stats_saturate", 128'(stat_count), 128'({4'd0, 4'd0, 4'hF, 4'd0}));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
